// File: rtl/mu0_pkg.sv
// Shared widths, ALU operation codes and instruction opcodes for MU0.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mu0_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int OPC_W  = DATA_W - ADDR_W;

    typedef enum logic [1:0] {
        ALU_Y   = 2'd0,
        ALU_ADD = 2'd1,
        ALU_INC = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_t;

    typedef enum logic [OPC_W-1:0] {
        LDA = 4'd0,
        STA = 4'd1,
        ADD = 4'd2,
        SUB = 4'd3,
        JMP = 4'd4,
        JGE = 4'd5,
        JNE = 4'd6,
        STP = 4'd7
    } opcode_t;

    // Build an instruction word from opcode and operand address.
    function automatic logic [DATA_W-1:0] mk_instr(opcode_t op, logic [ADDR_W-1:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/mu0_datapath_if.sv
// Control-to-datapath bundle: enables/selects in, memory bus and flags out.
// Latency: n/a (wires only).
// Backpressure: none; the datapath accepts a new control word every cycle.
interface mu0_datapath_if;
    import mu0_pkg::*;

    logic                  pc_en;
    logic                  ir_en;
    logic                  acc_en;
    logic                  x_sel;
    logic                  y_sel;
    logic                  addr_sel;
    alu_op_t               m;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W-1:0]     data_out;
    logic [ADDR_W-1:0]     address;
    logic [OPC_W-1:0]      f;
    logic                  n;
    logic                  z;
    logic [ADDR_W-1:0]     pc_q;
    logic [DATA_W-1:0]     ir_q;
    logic [DATA_W-1:0]     acc_q;

    // Control unit / memory side.
    modport master (
        output pc_en, ir_en, acc_en, x_sel, y_sel, addr_sel, m, data_in,
        input  data_out, address, f, n, z, pc_q, ir_q, acc_q
    );

    // Datapath side.
    modport slave (
        input  pc_en, ir_en, acc_en, x_sel, y_sel, addr_sel, m, data_in,
        output data_out, address, f, n, z, pc_q, ir_q, acc_q
    );

endinterface

// File: rtl/mu0_alu.sv
// Four-function ALU: pass Y, X+Y, X+1, X-Y, all modulo 2^DATA_W.
// Latency: combinational, zero cycles.
// Backpressure: none.
module mu0_alu import mu0_pkg::*; #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  alu_op_t           m,
    output logic [DATA_W-1:0] result
);

    // Select the operation; carries out of the top bit are dropped.
    always_comb begin
        result = y;
        case (m)
            ALU_Y:   result = y;
            ALU_ADD: result = x + y;
            ALU_INC: result = x + DATA_W'(1);
            ALU_SUB: result = x - y;
            default: result = y;
        endcase
    end

endmodule

// File: rtl/mu0_datapath.sv
// MU0 datapath: PC/IR/Acc registers, X/Y/address muxes and the ALU.
// Latency: one clk edge from enable to register; muxes/ALU are zero-cycle.
// Backpressure: none; every enabled edge loads unconditionally.
module mu0_datapath import mu0_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    mu0_datapath_if.slave bus
);

    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] acc_r;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_res;

    assign operand = ir_r[ADDR_W-1:0];

    // Operand and address muxes; PC and IR operand are zero-extended to DATA_W.
    assign alu_x = bus.x_sel ? {{OPC_W{1'b0}}, pc_r}    : acc_r;
    assign alu_y = bus.y_sel ? {{OPC_W{1'b0}}, operand} : bus.data_in;

    mu0_alu #(.DATA_W(DATA_W)) u_alu (
        .x      (alu_x),
        .y      (alu_y),
        .m      (bus.m),
        .result (alu_res)
    );

    // PC keeps only the low address bits of the ALU result, so PC+1 wraps at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_r <= '0;
        else if (bus.pc_en)
            pc_r <= alu_res[ADDR_W-1:0];
    end

    // IR captures memory read data as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ir_r <= '0;
        else if (bus.ir_en)
            ir_r <= bus.data_in;
    end

    // Acc takes the full-width ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_r <= '0;
        else if (bus.acc_en)
            acc_r <= alu_res;
    end

    // Flags come from the registered Acc only, so they never glitch with selects.
    assign bus.n        = acc_r[DATA_W-1];
    assign bus.z        = (acc_r == '0);
    assign bus.f        = ir_r[DATA_W-1:ADDR_W];
    assign bus.address  = bus.addr_sel ? operand : pc_r;
    assign bus.data_out = alu_x;
    assign bus.pc_q     = pc_r;
    assign bus.ir_q     = ir_r;
    assign bus.acc_q    = acc_r;

endmodule

// File: tb/tb_mu0_datapath.sv
// Directed self-checking bench for mu0_datapath.
// Latency: inputs driven 1ns after posedge, outputs sampled before next edge.
// Backpressure: n/a.
module tb_mu0_datapath;
    import mu0_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mu0_datapath_if bus();

    mu0_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_en    = 1'b0;
        bus.ir_en    = 1'b0;
        bus.acc_en   = 1'b0;
        bus.x_sel    = 1'b0;
        bus.y_sel    = 1'b0;
        bus.addr_sel = 1'b0;
        bus.m        = ALU_Y;
    endtask

    task automatic load_acc(input logic [15:0] v);
        idle();
        bus.data_in = v;
        bus.acc_en  = 1'b1;
        step();
        idle();
    endtask

    task automatic load_ir(input logic [15:0] v);
        idle();
        bus.data_in = v;
        bus.ir_en   = 1'b1;
        step();
        idle();
    endtask

    // Goes through IR, so IR is left holding {4'h0, v}.
    task automatic load_pc(input logic [11:0] v);
        load_ir({4'h0, v});
        bus.y_sel = 1'b1;
        bus.m     = ALU_Y;
        bus.pc_en = 1'b1;
        step();
        idle();
    endtask

    task automatic set_fetch(input logic [15:0] mem_word);
        idle();
        bus.x_sel    = 1'b1;
        bus.m        = ALU_INC;
        bus.addr_sel = 1'b0;
        bus.pc_en    = 1'b1;
        bus.ir_en    = 1'b1;
        bus.data_in  = mem_word;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        bus.data_in = 16'hA5A5;

        // Power-on reset values
        #3;
        check("rst_pc",   32'(bus.pc_q), 32'h000);
        check("rst_ir",   32'(bus.ir_q), 32'h0000);
        check("rst_acc",  32'(bus.acc_q), 32'h0000);
        check("rst_addr", 32'(bus.address), 32'h000);
        check("rst_f",    32'(bus.f), 32'h0);
        check("rst_n",    32'(bus.n), 32'h0);
        check("rst_z",    32'(bus.z), 32'h1);
        check("rst_dout_acc", 32'(bus.data_out), 32'h0000);
        bus.x_sel = 1'b1;
        #1;
        check("rst_dout_pc", 32'(bus.data_out), 32'h0000);
        #4;  // mid-cycle release at t=8
        rst = 1'b0;
        idle();
        step();
        check("post_rst_pc", 32'(bus.pc_q), 32'h000);

        // Asynchronous reset between edges with loaded registers
        load_pc(12'h123);
        load_acc(16'h8000);
        check("pre_rst_pc",  32'(bus.pc_q), 32'h123);
        check("pre_rst_acc", 32'(bus.acc_q), 32'h8000);
        check("pre_rst_n",   32'(bus.n), 32'h1);
        bus.pc_en = 1'b1; bus.ir_en = 1'b1; bus.acc_en = 1'b1;
        bus.data_in = 16'h7777;
        #2;
        rst = 1'b1;
        #1;
        check("async_pc",  32'(bus.pc_q), 32'h000);
        check("async_ir",  32'(bus.ir_q), 32'h0000);
        check("async_acc", 32'(bus.acc_q), 32'h0000);
        check("async_z",   32'(bus.z), 32'h1);
        check("async_n",   32'(bus.n), 32'h0);
        step();
        check("rst_edge_acc", 32'(bus.acc_q), 32'h0000);
        #2;
        rst = 1'b0;
        idle();
        step();
        check("rst_rel_ir", 32'(bus.ir_q), 32'h0000);

        // Fetch: IR <= mem[PC], PC <= PC+1 on one edge
        load_pc(12'h005);
        set_fetch(16'h2123);
        #1;
        check("fetch_addr", 32'(bus.address), 32'h005);
        check("fetch_dout", 32'(bus.data_out), 32'h0005);
        step();
        check("fetch_ir", 32'(bus.ir_q), 32'h2123);
        check("fetch_pc", 32'(bus.pc_q), 32'h006);
        check("fetch_f",  32'(bus.f), 32'h2);

        // ADD: Acc <= Acc + mem[operand]
        load_acc(16'h0010);
        bus.addr_sel = 1'b1;
        bus.data_in  = 16'h0005;
        bus.m        = ALU_ADD;
        bus.acc_en   = 1'b1;
        #1;
        check("add_addr", 32'(bus.address), 32'h123);
        step();
        check("add_acc", 32'(bus.acc_q), 32'h0015);
        check("add_n",   32'(bus.n), 32'h0);
        check("add_z",   32'(bus.z), 32'h0);

        // SUB going negative, then to zero
        load_acc(16'h0003);
        bus.data_in = 16'h0005;
        bus.m       = ALU_SUB;
        bus.acc_en  = 1'b1;
        step();
        check("sub_acc", 32'(bus.acc_q), 32'hFFFE);
        check("sub_n",   32'(bus.n), 32'h1);
        check("sub_z",   32'(bus.z), 32'h0);
        bus.data_in = 16'hFFFE;
        step();
        check("sub0_acc", 32'(bus.acc_q), 32'h0000);
        check("sub0_z",   32'(bus.z), 32'h1);
        check("sub0_n",   32'(bus.n), 32'h0);

        // Acc increment wraps modulo 2^16
        load_acc(16'hFFFF);
        bus.m      = ALU_INC;
        bus.acc_en = 1'b1;
        step();
        check("inc_wrap_acc", 32'(bus.acc_q), 32'h0000);

        // JMP: PC <= IR operand
        load_ir(mk_instr(JMP, 12'hABC));
        bus.y_sel = 1'b1;
        bus.m     = ALU_Y;
        bus.pc_en = 1'b1;
        step();
        check("jmp_pc", 32'(bus.pc_q), 32'hABC);
        check("jmp_f",  32'(bus.f), 32'h4);

        // Fetch from top of memory wraps PC to 0
        load_pc(12'hFFF);
        set_fetch(16'h7000);
        #1;
        check("wrap_addr", 32'(bus.address), 32'hFFF);
        step();
        check("wrap_pc", 32'(bus.pc_q), 32'h000);
        check("wrap_ir", 32'(bus.ir_q), 32'h7000);

        // STA with all enables low: registers hold for three edges
        load_acc(16'h1234);
        load_ir(16'h1456);
        idle();
        bus.addr_sel = 1'b1;
        bus.data_in  = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sta_dout", 32'(bus.data_out), 32'h1234);
        end
        check("sta_addr", 32'(bus.address), 32'h456);
        check("hold_pc",  32'(bus.pc_q), 32'h000);
        check("hold_ir",  32'(bus.ir_q), 32'h1456);
        check("hold_acc", 32'(bus.acc_q), 32'h1234);
        check("hold_f",   32'(bus.f), 32'h1);
        bus.x_sel = 1'b1;
        #1;
        check("dout_pc_sel", 32'(bus.data_out), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
